deser_10bit_align: RTL and testbench
====================================

DESER_10BIT_ALIGN -- requirements
Module: deser_10bit_align

Interface
REQ-001 SHALL have parameter MISS_MAX, default 3: count of consecutive off-boundary commas that forces loss of lock.
REQ-002 SHALL have port clk  input  1  rising-edge clock, one serial bit per cycle.
REQ-003 SHALL have port rst_n  input  1  reset, synchronous, active-low.
REQ-004 SHALL have port ser_in  input  1  serial data, LSB-first, first received bit = word bit 0.
REQ-005 SHALL have port align_en  input  1  enables comma hunting and lock-loss checking.
REQ-006 SHALL have port par_out  output  10  last aligned word, registered.
REQ-007 SHALL have port par_valid  output  1  one-cycle strobe, par_out updated this cycle.
REQ-008 SHALL have port locked  output  1  high while state = LOCKED.
REQ-009 SHALL have port comma_det  output  1  qualifies par_valid: current par_out is a comma.

Function
REQ-010 SHALL shift every cycle: shift_reg <= {ser_in, shift_reg[9:1]}; next_win = {ser_in, shift_reg[9:1]}.
REQ-011 SHALL flag match when next_win == COMMA_NEG (10'h17C) or COMMA_POS (10'h283), i.e. K28.5 in either disparity.
REQ-012 SHALL keep bit_cnt 0..9, incrementing every cycle, wrapping 9->0; boundary = (bit_cnt == 9) in the current cycle.
REQ-013 SHALL implement FSM states HUNT, CONFIRM, LOCKED.
REQ-014 HUNT: match && align_en -> bit_cnt <= 0, go CONFIRM; otherwise stay; no par_valid.
REQ-015 CONFIRM: boundary && match -> LOCKED; boundary && !match -> HUNT; off-boundary match -> bit_cnt <= 0, stay CONFIRM; no par_valid.
REQ-016 LOCKED: at every boundary par_out <= next_win, par_valid <= 1, comma_det <= match; else par_valid <= 0, comma_det <= 0.
REQ-017 LOCKED: on-boundary match clears miss_cnt; off-boundary match with align_en increments miss_cnt; reaching MISS_MAX -> HUNT, miss_cnt <= 0.
REQ-018 align_en = 0 SHALL freeze state and miss_cnt; LOCKED continues delivering words at the held phase.
REQ-019 Latency: word whose bit 9 is sampled at edge E SHALL appear on par_out with par_valid high immediately after edge E.
REQ-020 locked SHALL rise after the edge that enters LOCKED (the confirming comma itself is delivered with par_valid, comma_det = 1) and fall after the edge that leaves LOCKED.
REQ-021 par_out SHALL hold its value between strobes and after lock loss.

Reset
REQ-022 rst_n = 0 at a clock edge SHALL clear shift_reg, bit_cnt, miss_cnt, par_out = 0, par_valid = 0, locked = 0, comma_det = 0, state = HUNT.
REQ-023 Reset mid-word or while LOCKED SHALL discard partial data; relock requires two fresh aligned commas.

Structure
REQ-024 Package serdes_pkg SHALL hold WORD_W = 10, COMMA_NEG, COMMA_POS, and the FSM state enum, shared with the serializer.
REQ-025 Comma comparison SHALL be a combinational sub-module comma_det_10b (in: 10-bit window, out: match).

Verification
REQ-026 Reset, send 0x17C, 0x17C, 0x2AA LSB-first -> locked = 1 after bit 20; par_out = 0x17C/comma_det = 1 at bit 20, 0x2AA/comma_det = 0 at bit 30, par_valid one cycle each.
REQ-027 Prepend 3 junk bits 3'b101, then 0x283, 0x283, 0x0F5 -> lock at the correct phase, par_out = 0x0F5.
REQ-028 While locked, insert one extra bit then send 0x17C x3 (all off-boundary) -> locked falls after the 3rd comma; next two commas relock.
REQ-029 Comma then 0x155 -> CONFIRM fails, back to HUNT, locked stays 0, no par_valid.
REQ-030 rst_n low for 1 cycle mid-word while locked -> all outputs 0 next cycle, state HUNT.
REQ-031 align_en = 0 in HUNT with repeated 0x17C -> locked stays 0; raising align_en -> lock within 20 bits.

Source files
------------

// File: rtl/serdes_pkg.sv
// Shared definitions for the 10-bit serdes path (deserializer and serializer).
package serdes_pkg;

    localparam int WORD_W    = 10;
    localparam int BIT_CNT_W = 4;

    // K28.5 in both running disparities, bit 0 is the first bit on the wire.
    localparam logic [WORD_W-1:0] COMMA_NEG = 10'h17C;
    localparam logic [WORD_W-1:0] COMMA_POS = 10'h283;

    // Index of the last bit of a word; its edge completes the word.
    localparam logic [BIT_CNT_W-1:0] LAST_BIT = BIT_CNT_W'(WORD_W - 1);

    typedef enum logic [1:0] {
        ST_HUNT    = 2'd0,
        ST_CONFIRM = 2'd1,
        ST_LOCKED  = 2'd2
    } align_state_e;

endpackage

// File: rtl/comma_det_10b.sv
// Combinational K28.5 detector on a 10-bit window, either disparity.
module comma_det_10b
    import serdes_pkg::*;
(
    input  logic [WORD_W-1:0] win_i,
    output logic              match_o
);

    // Window matches when it equals either disparity form of the comma.
    always_comb begin
        match_o = (win_i == COMMA_NEG) || (win_i == COMMA_POS);
    end

endmodule

// File: rtl/deser_10bit_align.sv
// Serial-to-10-bit deserializer with comma-based word alignment.
// A comma seen in HUNT sets the word phase; a second comma exactly one word
// later confirms it. While locked, words are delivered at each boundary and
// MISS_MAX consecutive off-phase commas force a return to HUNT.
module deser_10bit_align
    import serdes_pkg::*;
#(
    parameter int MISS_MAX = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ser_in,
    input  logic              align_en,
    output logic [WORD_W-1:0] par_out,
    output logic              par_valid,
    output logic              locked,
    output logic              comma_det
);

    localparam int MISS_W = (MISS_MAX < 2) ? 1 : $clog2(MISS_MAX + 1);

    // Only bits 9..1 are kept: bit 0 of the old window falls off on the
    // next shift, so it never contributes to a future window.
    logic [WORD_W-1:1]    shift_q,     shift_d;
    logic [BIT_CNT_W-1:0] bit_cnt_q,   bit_cnt_d;
    logic [MISS_W-1:0]    miss_cnt_q,  miss_cnt_d;
    align_state_e         state_q,     state_d;
    logic [WORD_W-1:0]    par_out_q,   par_out_d;
    logic                 par_valid_q, par_valid_d;
    logic                 comma_q,     comma_d;

    logic [WORD_W-1:0]    next_win;
    logic                 match;
    logic                 boundary;
    logic [MISS_W-1:0]    miss_inc;

    assign next_win = {ser_in, shift_q};
    assign boundary = (bit_cnt_q == LAST_BIT);
    assign miss_inc = miss_cnt_q + MISS_W'(1);

    comma_det_10b u_comma (
        .win_i   (next_win),
        .match_o (match)
    );

    // Next-state logic: shifting, phase counter, alignment FSM, word delivery.
    always_comb begin
        // NOTE: every _d gets a default before the case, so no path can leave
        // one unassigned and infer a latch.
        shift_d     = next_win[WORD_W-1:1];
        bit_cnt_d   = boundary ? '0 : bit_cnt_q + BIT_CNT_W'(1);
        miss_cnt_d  = miss_cnt_q;
        state_d     = state_q;
        par_out_d   = par_out_q;
        par_valid_d = 1'b0;
        comma_d     = 1'b0;

        unique case (state_q)
            ST_HUNT: begin
                // First comma defines a candidate phase.
                if (match && align_en) begin
                    bit_cnt_d = '0;
                    state_d   = ST_CONFIRM;
                end
            end
            ST_CONFIRM: begin
                if (align_en) begin
                    if (boundary) begin
                        if (match) begin
                            // Confirming comma is itself delivered as a word.
                            state_d     = ST_LOCKED;
                            par_out_d   = next_win;
                            par_valid_d = 1'b1;
                            comma_d     = 1'b1;
                        end else begin
                            state_d = ST_HUNT;
                        end
                    end else if (match) begin
                        // A later comma wins: restart the phase from it.
                        bit_cnt_d = '0;
                    end
                end
            end
            ST_LOCKED: begin
                if (boundary) begin
                    par_out_d   = next_win;
                    par_valid_d = 1'b1;
                    comma_d     = match;
                end
                if (align_en && match) begin
                    if (boundary) begin
                        miss_cnt_d = '0;
                    end else if (miss_inc == MISS_W'(MISS_MAX)) begin
                        state_d    = ST_HUNT;
                        miss_cnt_d = '0;
                    end else begin
                        miss_cnt_d = miss_inc;
                    end
                end
            end
            default: begin
                state_d = ST_HUNT;
            end
        endcase
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments so every register samples values
        // from before the edge, independent of statement order.
        if (!rst_n) begin
            shift_q     <= '0;
            bit_cnt_q   <= '0;
            miss_cnt_q  <= '0;
            state_q     <= ST_HUNT;
            par_out_q   <= '0;
            par_valid_q <= 1'b0;
            comma_q     <= 1'b0;
        end else begin
            shift_q     <= shift_d;
            bit_cnt_q   <= bit_cnt_d;
            miss_cnt_q  <= miss_cnt_d;
            state_q     <= state_d;
            par_out_q   <= par_out_d;
            par_valid_q <= par_valid_d;
            comma_q     <= comma_d;
        end
    end

    assign par_out   = par_out_q;
    assign par_valid = par_valid_q;
    assign comma_det = comma_q;
    assign locked    = (state_q == ST_LOCKED);

endmodule

// File: tb/tb_deser_10bit_align.sv
// Self-checking bench for deser_10bit_align: table vectors, directed corner
// sequences and a randomized stream compared against a behavioural model.
module tb_deser_10bit_align;

    localparam int MISS_MAX = 3;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       ser_in = 1'b0;
    logic       align_en = 1'b0;
    logic [9:0] par_out;
    logic       par_valid;
    logic       locked;
    logic       comma_det;

    int checks = 0;
    int errors = 0;
    int valid_cnt = 0;
    int comma_cnt = 0;
    bit cmp_model = 1'b0;

    deser_10bit_align #(.MISS_MAX(MISS_MAX)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .ser_in    (ser_in),
        .align_en  (align_en),
        .par_out   (par_out),
        .par_valid (par_valid),
        .locked    (locked),
        .comma_det (comma_det)
    );

    always #5 clk = ~clk;

    // ---------------- behavioural reference model ----------------
    typedef enum {M_HUNT, M_CONF, M_LOCK} mstate_t;
    mstate_t    m_st;
    bit         m_bits[$];     // last ten received bits, oldest first
    int         m_pos;         // bits received since the phase reference
    int         m_miss;
    logic [9:0] m_out;
    logic       m_val;
    logic       m_com;

    function automatic void model_reset();
        m_bits.delete();
        for (int i = 0; i < 10; i++) m_bits.push_back(1'b0);
        m_st = M_HUNT; m_pos = 0; m_miss = 0;
        m_out = '0; m_val = 1'b0; m_com = 1'b0;
    endfunction

    function automatic void model_step(input bit b, input bit en);
        logic [9:0] win;
        bit word_end, hit, realign;
        m_bits.push_back(b);
        void'(m_bits.pop_front());
        for (int i = 0; i < 10; i++) win[i] = m_bits[i];
        hit      = (win == 10'h17C) || (win == 10'h283);
        word_end = (m_pos % 10) == 9;
        realign  = 1'b0;
        m_val    = 1'b0;
        m_com    = 1'b0;
        case (m_st)
            M_HUNT: if (hit && en) begin m_st = M_CONF; realign = 1'b1; end
            M_CONF: if (en) begin
                if (word_end) begin
                    if (hit) begin m_st = M_LOCK; m_out = win; m_val = 1'b1; m_com = 1'b1; end
                    else m_st = M_HUNT;
                end else if (hit) realign = 1'b1;
            end
            M_LOCK: begin
                if (word_end) begin m_out = win; m_val = 1'b1; m_com = hit; end
                if (en && hit) begin
                    if (word_end) m_miss = 0;
                    else begin
                        m_miss++;
                        if (m_miss >= MISS_MAX) begin m_st = M_HUNT; m_miss = 0; end
                    end
                end
            end
            default: m_st = M_HUNT;
        endcase
        m_pos = realign ? 0 : m_pos + 1;
    endfunction

    // ---------------- helpers ----------------
    task automatic check(input string name, input logic [9:0] act, input logic [9:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic send_bit(input bit b);
        @(negedge clk);
        rst_n  = 1'b1;
        ser_in = b;
        @(posedge clk);
        #1;
        model_step(b, align_en);
        if (par_valid) valid_cnt++;
        if (par_valid && comma_det) comma_cnt++;
        if (cmp_model) begin
            check("rand_locked",    {9'd0, locked},    {9'd0, m_st == M_LOCK});
            check("rand_par_valid", {9'd0, par_valid}, {9'd0, m_val});
            check("rand_comma_det", {9'd0, comma_det}, {9'd0, m_com});
            check("rand_par_out",   par_out,           m_out);
        end
    endtask

    task automatic send_word(input logic [9:0] w);
        for (int i = 0; i < 10; i++) send_bit(w[i]);
    endtask

    task automatic reset_cycle();
        @(negedge clk);
        rst_n  = 1'b0;
        ser_in = 1'($urandom_range(0, 1));
        @(posedge clk);
        #1;
        model_reset();
        valid_cnt = 0;
        comma_cnt = 0;
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        string      name;
        int         junk_len;
        logic [9:0] junk;
        logic [9:0] w0, w1, w2;
        logic       exp_locked;
        logic [9:0] exp_out;
        int         exp_valids;
        int         exp_commas;
    } vec_t;

    vec_t vecs[5];

    initial begin
        vecs[0] = '{"neg_lock",    0, 10'h000, 10'h17C, 10'h17C, 10'h2AA, 1'b1, 10'h2AA, 2, 1};
        vecs[1] = '{"pos_junk3",   3, 10'h005, 10'h283, 10'h283, 10'h0F5, 1'b1, 10'h0F5, 2, 1};
        vecs[2] = '{"confirm_bad", 0, 10'h000, 10'h17C, 10'h155, 10'h000, 1'b0, 10'h000, 0, 0};
        vecs[3] = '{"mixed_disp",  5, 10'h006, 10'h283, 10'h17C, 10'h3FF, 1'b1, 10'h3FF, 2, 1};
        vecs[4] = '{"late_comma",  0, 10'h000, 10'h2AA, 10'h17C, 10'h17C, 1'b1, 10'h17C, 1, 1};

        model_reset();
        reset_cycle();

        // Reset state.
        check("reset_par_out",   par_out,             10'h000);
        check("reset_par_valid", {9'd0, par_valid},   10'h000);
        check("reset_locked",    {9'd0, locked},      10'h000);
        check("reset_comma_det", {9'd0, comma_det},   10'h000);

        // Table-driven sequences.
        for (int v = 0; v < 5; v++) begin
            reset_cycle();
            align_en = 1'b1;
            for (int i = 0; i < vecs[v].junk_len; i++) send_bit(vecs[v].junk[i]);
            send_word(vecs[v].w0);
            send_word(vecs[v].w1);
            send_word(vecs[v].w2);
            check({vecs[v].name, "_locked"},  {9'd0, locked}, {9'd0, vecs[v].exp_locked});
            check({vecs[v].name, "_par_out"}, par_out,        vecs[v].exp_out);
            check({vecs[v].name, "_valids"},  10'(valid_cnt), 10'(vecs[v].exp_valids));
            check({vecs[v].name, "_commas"},  10'(comma_cnt), 10'(vecs[v].exp_commas));
        end

        // Lock timing and single-cycle strobes.
        reset_cycle();
        align_en = 1'b1;
        send_word(10'h17C);
        check("lat_locked_bit10", {9'd0, locked}, 10'h000);
        send_word(10'h17C);
        check("lat_locked_bit20",    {9'd0, locked},    10'h001);
        check("lat_valid_bit20",     {9'd0, par_valid}, 10'h001);
        check("lat_comma_bit20",     {9'd0, comma_det}, 10'h001);
        check("lat_par_out_bit20",   par_out,           10'h17C);
        send_bit(1'b0);
        check("lat_valid_bit21",     {9'd0, par_valid}, 10'h000);
        check("lat_hold_bit21",      par_out,           10'h17C);
        for (int i = 1; i < 10; i++) send_bit(1'((10'h2AA >> i) & 10'h001));
        check("lat_par_out_bit30",   par_out,           10'h2AA);
        check("lat_comma_bit30",     {9'd0, comma_det}, 10'h000);
        check("lat_valid_bit30",     {9'd0, par_valid}, 10'h001);

        // Slip by one bit: three off-phase commas drop lock, two more relock.
        reset_cycle();
        align_en = 1'b1;
        repeat (3) send_word(10'h17C);
        send_bit(1'b0);
        send_word(10'h17C);
        send_word(10'h17C);
        check("slip_locked_after2", {9'd0, locked}, 10'h001);
        check("slip_word_shifted",  par_out,        10'h2F8);
        send_word(10'h17C);
        check("slip_locked_after3", {9'd0, locked}, 10'h000);
        send_bit(1'b0);
        check("slip_hold_after_loss", par_out, 10'h2F8);
        for (int i = 1; i < 10; i++) send_bit(1'((10'h17C >> i) & 10'h001));
        send_word(10'h17C);
        check("slip_relock", {9'd0, locked}, 10'h001);
        check("slip_relock_word", par_out, 10'h17C);

        // Reset mid-word while locked.
        reset_cycle();
        align_en = 1'b1;
        send_word(10'h17C);
        send_word(10'h17C);
        for (int i = 0; i < 5; i++) send_bit(1'((10'h2AA >> i) & 10'h001));
        reset_cycle();
        check("midrst_par_out",   par_out,           10'h000);
        check("midrst_par_valid", {9'd0, par_valid}, 10'h000);
        check("midrst_locked",    {9'd0, locked},    10'h000);
        check("midrst_comma_det", {9'd0, comma_det}, 10'h000);
        send_word(10'h17C);
        check("midrst_one_comma", {9'd0, locked}, 10'h000);
        send_word(10'h17C);
        check("midrst_two_commas", {9'd0, locked}, 10'h001);

        // align_en low in HUNT holds off locking.
        reset_cycle();
        align_en = 1'b0;
        repeat (4) send_word(10'h17C);
        check("en_off_locked", {9'd0, locked}, 10'h000);
        check("en_off_valids", 10'(valid_cnt), 10'h000);
        align_en = 1'b1;
        send_word(10'h17C);
        check("en_on_first", {9'd0, locked}, 10'h000);
        send_word(10'h17C);
        check("en_on_lock20", {9'd0, locked}, 10'h001);

        // Randomized stream against the reference model.
        reset_cycle();
        align_en  = 1'b1;
        cmp_model = 1'b1;
        for (int c = 0; c < 300; c++) begin
            int r;
            r = int'($urandom_range(0, 99));
            if (r < 2) reset_cycle();
            else if (r < 12) align_en = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 1) != 0) begin
                send_word(($urandom_range(0, 1) != 0) ? 10'h17C : 10'h283);
            end else begin
                int n;
                n = int'($urandom_range(1, 12));
                for (int i = 0; i < n; i++) send_bit(1'($urandom_range(0, 1)));
            end
        end
        cmp_model = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
